data_memory_responder: RTL and testbench
========================================

Name: data_memory_responder

Overview:
- Responder end of the CPU data-memory interface.
- Accepts load/store requests from an initiator over a valid/ready request channel and holds them for a configurable latency.
- Performs the word access with byte strobes and returns the result over a valid/ready response channel.
- Replaces the combinational zero-latency data memory when the core moves to a handshaked load/store unit.

Parameters:
- DEPTH, 32, number of 32-bit words held (word index = addr[31:2]).
- LATENCY, 2, cycles from request-accept edge to the first edge at which the response can be consumed; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous reset, active-low (0 = reset).
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i].
- resp_valid  output  1  response present.
- resp_ready  input  1  initiator consumes the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_error  output  1  access was misaligned or out of range.
- initial_values  input  32 x DEPTH  memory contents loaded during reset.
- memory_check  output  32 x DEPTH  combinational view of all memory words.

Behaviour:
- Reset (reset==0 at a rising edge):
  - mem[i] <= initial_values[i] for all i.
  - state <= IDLE, counter <= 0, resp_rdata <= 0, resp_error <= 0.
  - While reset==0: req_ready=0, resp_valid=0.
- States:
  - IDLE: req_ready=1 (when reset==1), resp_valid=0.
  - WAIT: req_ready=0, resp_valid=0.
  - RESP: req_ready=0, resp_valid=1.
- Accept: occurs when req_valid && req_ready at a rising edge. Latch write, addr, wdata, wstrb. Load counter <= LATENCY-1. Next state is RESP if LATENCY==1, otherwise WAIT.
- WAIT: counter decrements each cycle. When counter==1, transition to RESP at that edge.
- Access on the transition into RESP:
  - Error condition: addr[1:0]!=0, or addr[31:2] >= DEPTH.
  - On error: resp_error <= 1, resp_rdata <= 0, no memory change.
  - Load, no error: resp_rdata <= mem[addr[31:2]], resp_error <= 0.
  - Store, no error: each byte with wstrb[i]=1 is replaced; other bytes are kept. resp_rdata <= 0, resp_error <= 0. wstrb=0 gives a normal response with no change.
- Timing: a response is consumable at the edge accept+LATENCY. Throughput is at most one transaction per LATENCY+1 cycles; no pipelining.
- RESP: stays in RESP with resp_rdata/resp_error stable while resp_ready==0. Transitions to IDLE at the edge where resp_ready==1. A new request can be accepted no earlier than the following edge.
- Request inputs are ignored outside IDLE; the initiator holds them stable until accepted.
- Reset mid-operation (WAIT or RESP): the transaction is discarded and memory is reloaded from initial_values. A store that has not yet committed is lost.
- memory_check reflects committed contents only; it updates the cycle after a store commits.

Decomposition:
- Shared package: state enum responder_state_t {IDLE, WAIT, RESP}, and a localparam for the counter width (4 bits).
- One sub-module: byte_lane_merge (combinational: old word, new word, wstrb -> merged word). It is reused later by the store path in the core.

Test Plan:
- Reset load: initial_values[i]=i*0x11111111, hold reset=0 for 2 cycles -> memory_check[5]=0x55555555, req_ready=0 during reset, resp_valid=0.
- Load latency: LATENCY=2, accept load addr=0x14 at edge T, resp_ready=1 -> resp_valid=1 after edge T+1, rdata=0x55555555, error=0; req_ready high again after edge T+2.
- Byte-strobe store: mem[3]=0x33333333, store addr=0x0C, wdata=0xAABBCCDD, wstrb=4'b0101 -> memory_check[3]=0x33BB33DD, resp_rdata=0, error=0.
- Errors: load addr=0x06 -> error=1, rdata=0. Store addr=0x80 (DEPTH=32) -> error=1, all memory_check unchanged.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid -> resp_valid stays 1, rdata constant, req_ready=0. resp_ready=1 -> IDLE next cycle.
- Reset mid-operation: store to addr=0x00 accepted, reset=0 in WAIT -> after reset memory_check[0]=initial_values[0], state IDLE, resp_valid=0.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared types for the data-memory responder.
// State encoding and counter sizing used by the top and its helpers.
package data_memory_responder_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } responder_state_t;

  localparam int CNT_W = 4;

endpackage

// File: rtl/data_memory_responder_byte_lane_merge.sv
// Byte-lane merge: take each byte from the new word where its strobe
// is set, otherwise keep the old byte.
module byte_lane_merge (
  input  logic [31:0] old_word,
  input  logic [31:0] new_word,
  input  logic [3:0]  wstrb,
  output logic [31:0] merged
);

  always_comb begin
    merged = old_word;
    for (int i = 0; i < 4; i++) begin
      if (wstrb[i]) merged[8*i +: 8] = new_word[8*i +: 8];
    end
  end

endmodule

// File: rtl/data_memory_responder.sv
// Handshaked data-memory responder: accepts one load/store, waits
// LATENCY cycles, performs the strobed word access, then responds.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int DEPTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [31:0]             req_wdata,
  input  logic [3:0]              req_wstrb,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [31:0]             resp_rdata,
  output logic                    resp_error,
  input  logic [DEPTH-1:0][31:0]  initial_values,
  output logic [DEPTH-1:0][31:0]  memory_check
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);
  localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LATENCY - 1);

  responder_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        wr_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;

  logic [DEPTH-1:0][31:0] mem;
  logic [31:0] rdata_q;
  logic        error_q;

  logic        accept;
  logic        enter_resp;
  logic        live;
  logic        acc_write;
  logic [31:0] acc_addr;
  logic [31:0] acc_wdata;
  logic [3:0]  acc_wstrb;
  logic        acc_err;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0] old_word;
  logic [31:0] merged;

  assign req_ready  = reset && (state_q == IDLE);
  assign resp_valid = reset && (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_error = error_q;
  assign memory_check = mem;

  assign accept = req_valid && req_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d = LAT_M1;
          if (LATENCY == 1) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // With LATENCY==1 the access happens on the accept edge itself,
  // so the live request bus is used instead of the latched copy.
  assign live      = (state_q == IDLE);
  assign acc_write = live ? req_write : wr_q;
  assign acc_addr  = live ? req_addr  : addr_q;
  assign acc_wdata = live ? req_wdata : wdata_q;
  assign acc_wstrb = live ? req_wstrb : wstrb_q;

  assign acc_err = (acc_addr[1:0] != 2'b00) ||
                   (acc_addr[31:2] >= DEPTH_W);
  assign acc_idx  = acc_addr[IDX_W+1:2];
  assign old_word = mem[acc_idx];

  byte_lane_merge u_merge (
    .old_word (old_word),
    .new_word (acc_wdata),
    .wstrb    (acc_wstrb),
    .merged   (merged)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      mem     <= initial_values;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q    <= req_write;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wstrb_q <= req_wstrb;
      end
      if (enter_resp) begin
        if (acc_err) begin
          error_q <= 1'b1;
          rdata_q <= '0;
        end else if (acc_write) begin
          mem[acc_idx] <= merged;
          error_q      <= 1'b0;
          rdata_q      <= '0;
        end else begin
          error_q <= 1'b0;
          rdata_q <= old_word;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Scoreboard bench for data_memory_responder (DEPTH=32, LATENCY=2).
// Directed requests push expected responses; a monitor pops and compares.
module tb_data_memory_responder;

  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic reset;
  logic req_valid;
  logic req_ready;
  logic req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic resp_valid;
  logic resp_ready;
  logic [31:0] resp_rdata;
  logic resp_error;
  logic [DEPTH-1:0][31:0] iv;
  logic [DEPTH-1:0][31:0] mc;
  logic [DEPTH-1:0][31:0] snap;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int compared = 0;
  int mismatched = 0;

  data_memory_responder #(.DEPTH(DEPTH), .LATENCY(2)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wstrb      (req_wstrb),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .initial_values (iv),
    .memory_check   (mc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a response is consumed when valid and ready are both high.
  always @(negedge clk) begin
    if (reset === 1'b1 && resp_valid === 1'b1 && resp_ready === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_resp: got rdata %h err %b expected none",
                 resp_rdata, resp_error);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("resp_rdata", resp_rdata, e.rdata);
        check("resp_error", 32'(resp_error), 32'(e.err));
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL timeout_req_ready: got 0 expected 1");
    end
  endtask

  task automatic issue(input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic ee,
                       input bit want);
    if (want) sb.push_back('{rdata: er, err: ee});
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_wstrb = s;
    req_valid = 1'b1;
    wait_ready();
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic transact(input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s,
                          input logic [31:0] er, input logic ee);
    issue(w, a, d, s, er, ee, 1'b1);
    wait_ready();
    sync();
  endtask

  initial begin
    bit seen;
    for (int i = 0; i < DEPTH; i++) iv[i] = 32'(i) * 32'h1111_1111;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b1;

    // Reset load
    @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    check("rst_mem5", mc[5], 32'h5555_5555);
    sync();
    reset = 1'b1;
    @(negedge clk);
    check("idle_req_ready", 32'(req_ready), 32'd1);
    sync();

    // Load latency: accept at T, response consumable at T+2
    sb.push_back('{rdata: 32'h5555_5555, err: 1'b0});
    req_write = 1'b0;
    req_addr  = 32'h14;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("wait_resp_valid", 32'(resp_valid), 32'd0);
    check("wait_req_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    check("t1_resp_valid", 32'(resp_valid), 32'd1);
    @(negedge clk);
    check("t2_req_ready", 32'(req_ready), 32'd1);
    check("t2_resp_valid", 32'(resp_valid), 32'd0);
    sync();

    // Byte-strobe store and readback
    transact(1'b1, 32'h0C, 32'hAABB_CCDD, 4'b0101, 32'h0, 1'b0);
    check("strb_mem3", mc[3], 32'h33BB_33DD);
    transact(1'b0, 32'h0C, 32'h0, 4'b0000, 32'h33BB_33DD, 1'b0);
    transact(1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, 32'h0, 1'b0);
    check("full_mem4", mc[4], 32'hDEAD_BEEF);
    transact(1'b1, 32'h10, 32'h0123_4567, 4'b0000, 32'h0, 1'b0);
    check("nostrb_mem4", mc[4], 32'hDEAD_BEEF);
    transact(1'b1, 32'h08, 32'h1234_5678, 4'b1000, 32'h0, 1'b0);
    check("hi_mem2", mc[2], 32'h1222_2222);

    // Boundaries and errors
    transact(1'b0, 32'h7C, 32'h0, 4'b0000, 32'h1111_110F, 1'b0);
    transact(1'b0, 32'h06, 32'h0, 4'b0000, 32'h0, 1'b1);
    transact(1'b0, 32'h80, 32'h0, 4'b0000, 32'h0, 1'b1);
    snap = mc;
    transact(1'b1, 32'h80, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    compared++;
    if (mc !== snap) begin
      mismatched++;
      $display("FAIL oob_store_mem: got changed contents expected unchanged");
    end
    transact(1'b1, 32'h0D, 32'hFFFF_FFFF, 4'b1111, 32'h0, 1'b1);
    check("mis_store_mem3", mc[3], 32'h33BB_33DD);

    // Backpressure
    resp_ready = 1'b0;
    issue(1'b0, 32'h14, 32'h0, 4'b0000, 32'h5555_5555, 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      compared++;
      mismatched++;
      $display("FAIL timeout_resp_valid: got 0 expected 1");
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      check("bp_rdata", resp_rdata, 32'h5555_5555);
    end
    sync();
    resp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_idle_ready", 32'(req_ready), 32'd1);
    check("bp_idle_valid", 32'(resp_valid), 32'd0);
    sync();

    // Reset mid-operation discards an uncommitted store
    transact(1'b1, 32'h00, 32'hCAFE_F00D, 4'b1111, 32'h0, 1'b0);
    check("pre_mem0", mc[0], 32'hCAFE_F00D);
    issue(1'b1, 32'h00, 32'h1234_5678, 4'b1111, 32'h0, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    sync();
    reset = 1'b1;
    @(negedge clk);
    check("reload_mem0", mc[0], 32'h0);
    check("reload_mem3", mc[3], 32'h3333_3333);
    check("post_rst_ready", 32'(req_ready), 32'd1);
    check("post_rst_valid", 32'(resp_valid), 32'd0);
    repeat (4) @(negedge clk);
    check("post_rst_valid2", 32'(resp_valid), 32'd0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
